cache_mem_arbiter: RTL and testbench

- Shares the single SRAM-like memory port between the instruction-cache miss path and the data-cache miss/uncached path.
- Sits between the cache top level and the AXI interface bridge.
- Owns request selection, transaction sequencing and the global arbitration stall.
- Allows one outstanding transaction at a time.
- Data side has priority; a starvation counter guarantees the instruction side forward progress.

---
 rtl/cache_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the instruction-cache and data-cache miss paths onto a single
// SRAM-like memory port, one outstanding transaction at a time.
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             inst_cache_req,
    input  logic [31:0]      inst_cache_addr,
    input  logic             inst_cache_wr,
    input  logic [1:0]       inst_cache_size,
    input  logic [31:0]      inst_cache_wdata,
    output logic [31:0]      inst_cache_rdata,
    output logic             inst_cache_dok,

    input  logic             data_cache_req,
    input  logic [31:0]      data_cache_addr,
    input  logic             data_cache_wr,
    input  logic [1:0]       data_cache_size,
    input  logic [31:0]      data_cache_wdata,
    output logic [31:0]      data_cache_rdata,
    output logic             data_cache_dok,

    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_size,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,

    output logic             stall_by_arbitrater,

    output logic [1:0]       dbg_state,
    output logic             dbg_owner,
    output logic [CNT_W-1:0] dbg_starve_cnt
);

    // Handshakes: a cache holds *_req high with stable fields until it sees
    // *_dok for one cycle, then drops req the next cycle. On the memory side
    // mem_req stays high with stable fields until mem_addr_ok; completion is
    // mem_data_ok (which may coincide with mem_addr_ok).

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      inst_rdata_q;
    logic [31:0]      data_rdata_q;

    logic complete;
    logic starved;
    logic grant_inst;
    logic grant_data;

    always_comb begin
        complete = 1'b0;
        case (state)
            ADDR:    complete = mem_addr_ok & mem_data_ok;
            DATA:    complete = mem_data_ok;
            default: complete = 1'b0;
        endcase
    end

    // Data wins ties unless the instruction side has waited STARVE_LIMIT grants.
    assign starved    = (starve_cnt == LIMIT);
    assign grant_inst = (state == IDLE) & inst_cache_req & (~data_cache_req | starved);
    assign grant_data = (state == IDLE) & data_cache_req & ~grant_inst;

    assign inst_cache_dok   = complete & (owner == OWN_INST);
    assign data_cache_dok   = complete & (owner == OWN_DATA);
    assign inst_cache_rdata = inst_cache_dok ? mem_rdata : inst_rdata_q;
    assign data_cache_rdata = data_cache_dok ? mem_rdata : data_rdata_q;

    // Gated by reset so the pipeline sees no stall while the block is held.
    assign stall_by_arbitrater = ~reset &
        ((inst_cache_req & ~inst_cache_dok) | (data_cache_req & ~data_cache_dok));

    assign dbg_state      = state;
    assign dbg_owner      = owner;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= OWN_DATA;
            starve_cnt   <= '0;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_size     <= 2'b00;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_inst) begin
                        owner     <= OWN_INST;
                        mem_addr  <= inst_cache_addr;
                        mem_wr    <= inst_cache_wr;
                        mem_size  <= inst_cache_size;
                        mem_wdata <= inst_cache_wdata;
                        mem_req   <= 1'b1;
                        state     <= ADDR;
                    end else if (grant_data) begin
                        owner     <= OWN_DATA;
                        mem_addr  <= data_cache_addr;
                        mem_wr    <= data_cache_wr;
                        mem_size  <= data_cache_size;
                        mem_wdata <= data_cache_wdata;
                        mem_req   <= 1'b1;
                        state     <= ADDR;
                    end

                    // Counts data grants that overtook a waiting inst request.
                    if (grant_inst || !inst_cache_req) begin
                        starve_cnt <= '0;
                    end else if (grant_data && starve_cnt != CNT_MAX) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= mem_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            if (inst_cache_dok) inst_rdata_q <= mem_rdata;
            if (data_cache_dok) data_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: requester queues per side, a
// latency-programmable memory model and an ordered expected-completion queue.
module tb_cache_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;
    localparam int REQ_W        = 67;   // {addr, wr, size, wdata}
    localparam int EXP_W        = 100;  // {side, addr, wr, size, wdata, rdata}
    localparam logic SIDE_INST  = 1'b0;
    localparam logic SIDE_DATA  = 1'b1;

    logic             clk = 1'b0;
    logic             reset;
    logic             inst_cache_req, inst_cache_wr, inst_cache_dok;
    logic [31:0]      inst_cache_addr, inst_cache_wdata, inst_cache_rdata;
    logic [1:0]       inst_cache_size;
    logic             data_cache_req, data_cache_wr, data_cache_dok;
    logic [31:0]      data_cache_addr, data_cache_wdata, data_cache_rdata;
    logic [1:0]       data_cache_size;
    logic             mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]       mem_size;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic             stall_by_arbitrater;
    logic [1:0]       dbg_state;
    logic             dbg_owner;
    logic [CNT_W-1:0] dbg_starve_cnt;

    cache_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
        .inst_cache_wr(inst_cache_wr), .inst_cache_size(inst_cache_size),
        .inst_cache_wdata(inst_cache_wdata), .inst_cache_rdata(inst_cache_rdata),
        .inst_cache_dok(inst_cache_dok),
        .data_cache_req(data_cache_req), .data_cache_addr(data_cache_addr),
        .data_cache_wr(data_cache_wr), .data_cache_size(data_cache_size),
        .data_cache_wdata(data_cache_wdata), .data_cache_rdata(data_cache_rdata),
        .data_cache_dok(data_cache_dok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .stall_by_arbitrater(stall_by_arbitrater),
        .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Clock / reset
    always #5 clk = ~clk;

    logic [REQ_W-1:0] inst_q[$];
    logic [REQ_W-1:0] data_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int               rise_q[$];
    int               dok_q[$];

    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    bit          inst_done, data_done;
    bit          mem_auto, mem_rand, in_data;
    bit          stray_addr_ok, stray_data_ok;
    int          addr_lat, data_lat, phase;
    bit          rdata_ovr_en;
    logic [31:0] rdata_ovr;
    logic [31:0] last_inst_rd, last_data_rd;
    logic        prev_mem_req;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (rdata_ovr_en) return rdata_ovr;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Driver tasks
    task automatic add_req(input logic side, input logic [31:0] a, input logic wr,
                           input logic [1:0] sz, input logic [31:0] wd);
        if (side == SIDE_INST) inst_q.push_back({a, wr, sz, wd});
        else                   data_q.push_back({a, wr, sz, wd});
    endtask

    task automatic expect_txn(input logic side, input logic [31:0] a, input logic wr,
                              input logic [1:0] sz, input logic [31:0] wd);
        exp_q.push_back({side, a, wr, sz, wd, mem_model(a)});
    endtask

    // One clock cycle: drive requesters and memory at negedge, then sample.
    task automatic tick();
        logic [REQ_W-1:0] h;
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] got;
        @(negedge clk);
        if (inst_done) begin
            if (inst_q.size() != 0) h = inst_q.pop_front();
            inst_done = 1'b0;
        end
        if (data_done) begin
            if (data_q.size() != 0) h = data_q.pop_front();
            data_done = 1'b0;
        end
        inst_cache_req = (inst_q.size() != 0);
        if (inst_cache_req) {inst_cache_addr, inst_cache_wr, inst_cache_size, inst_cache_wdata} = inst_q[0];
        data_cache_req = (data_q.size() != 0);
        if (data_cache_req) {data_cache_addr, data_cache_wr, data_cache_size, data_cache_wdata} = data_q[0];

        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = $urandom();
        if (mem_auto) begin
            if (in_data) begin
                phase++;
                if (phase >= data_lat) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = mem_model(mem_addr);
                    in_data     = 1'b0;
                    phase       = 0;
                end
            end else if (mem_req) begin
                if (phase >= addr_lat) begin
                    mem_addr_ok = 1'b1;
                    phase       = 0;
                    if (data_lat == 0) begin
                        mem_data_ok = 1'b1;
                        mem_rdata   = mem_model(mem_addr);
                    end else begin
                        in_data = 1'b1;
                    end
                end else begin
                    phase++;
                end
            end
            if (mem_data_ok && mem_rand) begin
                addr_lat = $urandom_range(0, 3);
                data_lat = $urandom_range(0, 3);
            end
        end else begin
            mem_addr_ok = stray_addr_ok;
            mem_data_ok = stray_data_ok;
        end

        #1;
        cycle++;
        if (mem_req && !prev_mem_req) rise_q.push_back(cycle);
        prev_mem_req = mem_req;

        // Scoreboard: every completion must match the head of exp_q.
        if (inst_cache_dok || data_cache_dok) begin
            dok_q.push_back(cycle);
            compared++;
            if (inst_cache_dok && data_cache_dok) begin
                mismatched++;
                $display("FAIL dok_both: got inst_dok=1 data_dok=1, required one at a time (cycle %0d)", cycle);
            end else if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL dok_unexpected: got inst_dok=%b data_dok=%b, required none (cycle %0d)",
                         inst_cache_dok, data_cache_dok, cycle);
            end else begin
                e   = exp_q.pop_front();
                got = {data_cache_dok, mem_addr, mem_wr, mem_size, mem_wdata,
                       data_cache_dok ? data_cache_rdata : inst_cache_rdata};
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL completion: got %h required %h (cycle %0d)", got, e, cycle);
                end
            end
            if (inst_cache_dok) inst_done = 1'b1;
            if (data_cache_dok) data_done = 1'b1;
        end

        compared++;
        if (inst_cache_rdata !== (inst_cache_dok ? mem_rdata : last_inst_rd)) begin
            mismatched++;
            $display("FAIL inst_rdata: got %h required %h (cycle %0d)", inst_cache_rdata,
                     inst_cache_dok ? mem_rdata : last_inst_rd, cycle);
        end
        compared++;
        if (data_cache_rdata !== (data_cache_dok ? mem_rdata : last_data_rd)) begin
            mismatched++;
            $display("FAIL data_rdata: got %h required %h (cycle %0d)", data_cache_rdata,
                     data_cache_dok ? mem_rdata : last_data_rd, cycle);
        end
        if (inst_cache_dok) last_inst_rd = mem_rdata;
        if (data_cache_dok) last_data_rd = mem_rdata;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL timeout: got %0d pending completions after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
            inst_q.delete();
            data_q.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        compared++;
        if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_cache_dok, data_cache_dok,
             stall_by_arbitrater} !== 70'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got req=%b wr=%b size=%b addr=%h wdata=%h idok=%b ddok=%b stall=%b, required all 0",
                     mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_cache_dok, data_cache_dok, stall_by_arbitrater);
        end
        compared++;
        if ({dbg_state, dbg_owner, dbg_starve_cnt} !== {2'd0, 1'b1, 3'd0}) begin
            mismatched++;
            $display("FAIL reset_state: got state=%0d owner=%b cnt=%0d, required state=0 owner=1 cnt=0",
                     dbg_state, dbg_owner, dbg_starve_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        rdata_ovr_en = 1'b1;
        rdata_ovr    = 32'hDEAD_BEEF;
        addr_lat = 1;
        data_lat = 2;
        add_req(SIDE_DATA, 32'h1000_0004, 1'b0, 2'b10, 32'h0);
        expect_txn(SIDE_DATA, 32'h1000_0004, 1'b0, 2'b10, 32'h0);
        for (int k = 0; k < 7; k++) begin
            tick();
            compared++;
            if (mem_req !== (k == 1 || k == 2)) begin
                mismatched++;
                $display("FAIL single_mem_req[%0d]: got %b required %b", k, mem_req, (k == 1 || k == 2));
            end
            compared++;
            if (stall_by_arbitrater !== (k <= 3)) begin
                mismatched++;
                $display("FAIL single_stall[%0d]: got %b required %b", k, stall_by_arbitrater, (k <= 3));
            end
            compared++;
            if (data_cache_dok !== (k == 4)) begin
                mismatched++;
                $display("FAIL single_dok[%0d]: got %b required %b", k, data_cache_dok, (k == 4));
            end
            if (k == 4) begin
                compared++;
                if (data_cache_rdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1000_0004) begin
                    mismatched++;
                    $display("FAIL single_rdata: got rdata=%h addr=%h required DEADBEEF/10000004",
                             data_cache_rdata, mem_addr);
                end
            end
        end
        rdata_ovr_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        addr_lat = 0;
        data_lat = 1;
        rise_q.delete();
        dok_q.delete();
        add_req(SIDE_INST, 32'hBFC0_0000, 1'b0, 2'b10, 32'h0);
        add_req(SIDE_DATA, 32'h8000_0010, 1'b0, 2'b10, 32'h0);
        expect_txn(SIDE_DATA, 32'h8000_0010, 1'b0, 2'b10, 32'h0);
        expect_txn(SIDE_INST, 32'hBFC0_0000, 1'b0, 2'b10, 32'h0);
        run_until_done(40);
        compared++;
        if (rise_q.size() != 2 || dok_q.size() != 2) begin
            mismatched++;
            $display("FAIL simul_counts: got %0d grants %0d doks, required 2 and 2", rise_q.size(), dok_q.size());
        end else if (rise_q[1] != dok_q[0] + 2) begin
            mismatched++;
            $display("FAIL simul_regrant: got inst mem_req at cycle %0d, required %0d", rise_q[1], dok_q[0] + 2);
        end
    endtask

    task automatic test_starvation();
        int          n = 0;
        logic [CNT_W-1:0] max_cnt = '0;
        logic [CNT_W-1:0] cnt_at_inst = '1;
        addr_lat = 0;
        data_lat = 1;
        add_req(SIDE_INST, 32'h0040_0000, 1'b0, 2'b10, 32'h0);
        for (int i = 0; i < 5; i++) add_req(SIDE_DATA, 32'h2000_0000 + 32'(i * 4), 1'b0, 2'b10, 32'h0);
        for (int i = 0; i < 4; i++) expect_txn(SIDE_DATA, 32'h2000_0000 + 32'(i * 4), 1'b0, 2'b10, 32'h0);
        expect_txn(SIDE_INST, 32'h0040_0000, 1'b0, 2'b10, 32'h0);
        expect_txn(SIDE_DATA, 32'h2000_0010, 1'b0, 2'b10, 32'h0);
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
            if (dbg_starve_cnt > max_cnt) max_cnt = dbg_starve_cnt;
            if (inst_cache_dok) cnt_at_inst = dbg_starve_cnt;
        end
        run_until_done(10);
        compared++;
        if (max_cnt !== 3'(STARVE_LIMIT)) begin
            mismatched++;
            $display("FAIL starve_max: got %0d required %0d", max_cnt, STARVE_LIMIT);
        end
        compared++;
        if (cnt_at_inst !== 3'd0) begin
            mismatched++;
            $display("FAIL starve_clear_on_inst: got %0d required 0", cnt_at_inst);
        end
        compared++;
        if (dbg_starve_cnt !== 3'd0) begin
            mismatched++;
            $display("FAIL starve_final: got %0d required 0", dbg_starve_cnt);
        end
    endtask

    task automatic test_zero_wait_write();
        int   n = 0;
        bit   saw_data = 1'b0;
        logic wr_seen = 1'b0;
        logic [1:0] size_seen = 2'b11;
        addr_lat = 0;
        data_lat = 0;
        rise_q.delete();
        dok_q.delete();
        add_req(SIDE_DATA, 32'h1000_0100, 1'b1, 2'b00, 32'h0000_00AB);
        expect_txn(SIDE_DATA, 32'h1000_0100, 1'b1, 2'b00, 32'h0000_00AB);
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
            if (dbg_state == 2'd2) saw_data = 1'b1;
            if (data_cache_dok) begin
                wr_seen   = mem_wr;
                size_seen = mem_size;
            end
        end
        run_until_done(5);
        compared++;
        if (saw_data || wr_seen !== 1'b1 || size_seen !== 2'b00) begin
            mismatched++;
            $display("FAIL zero_wait_write: got data_state=%b wr=%b size=%b, required 0/1/00", saw_data, wr_seen, size_seen);
        end
        compared++;
        if (dok_q.size() != 1 || rise_q.size() != 1 || dok_q[0] != rise_q[0]) begin
            mismatched++;
            $display("FAIL zero_wait_latency: got %0d doks %0d grants, required dok in first ADDR cycle",
                     dok_q.size(), rise_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        addr_lat = 0;
        data_lat = 6;
        add_req(SIDE_DATA, 32'h3000_0000, 1'b0, 2'b10, 32'h0);
        while (dbg_state != 2'd2 && n < 10) begin
            tick();
            n++;
        end
        compared++;
        if (dbg_state !== 2'd2) begin
            mismatched++;
            $display("FAIL reset_mid_reach: got state %0d required 2", dbg_state);
        end
        @(negedge clk);
        reset       = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        compared++;
        if ({mem_req, data_cache_dok, inst_cache_dok, stall_by_arbitrater, dbg_state} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_async: got req=%b ddok=%b idok=%b stall=%b state=%0d, required all 0",
                     mem_req, data_cache_dok, inst_cache_dok, stall_by_arbitrater, dbg_state);
        end
        data_q.delete();
        data_done = 1'b0;
        data_cache_req = 1'b0;
        in_data = 1'b0;
        phase = 0;
        @(negedge clk);
        reset = 1'b0;
        last_inst_rd = 32'h0;
        last_data_rd = 32'h0;
        mem_auto = 1'b0;
        stray_data_ok = 1'b1;
        tick();
        compared++;
        if (data_cache_dok !== 1'b0 || dbg_state !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_stray_ok: got dok=%b state=%0d required 0/0", data_cache_dok, dbg_state);
        end
        stray_data_ok = 1'b0;
        mem_auto = 1'b1;
    endtask

    task automatic test_spurious_idle();
        mem_auto = 1'b0;
        stray_addr_ok = 1'b1;
        stray_data_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if ({inst_cache_dok, data_cache_dok, stall_by_arbitrater, mem_req, dbg_state} !== 6'b0) begin
                mismatched++;
                $display("FAIL spurious_idle[%0d]: got idok=%b ddok=%b stall=%b req=%b state=%0d, required all 0",
                         k, inst_cache_dok, data_cache_dok, stall_by_arbitrater, mem_req, dbg_state);
            end
        end
        stray_addr_ok = 1'b0;
        stray_data_ok = 1'b0;
        mem_auto = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, wd;
        logic        wr;
        logic [1:0]  sz;
        mem_rand = 1'b1;
        addr_lat = $urandom_range(0, 3);
        data_lat = $urandom_range(0, 3);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                a  = $urandom();
                wd = $urandom();
                wr = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 2));
                add_req(s[0] ? SIDE_DATA : SIDE_INST, a, wr, sz, wd);
                expect_txn(s[0] ? SIDE_DATA : SIDE_INST, a, wr, sz, wd);
            end
            run_until_done(200);
        end
        mem_rand = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        inst_cache_req = 1'b0; inst_cache_addr = '0; inst_cache_wr = 1'b0;
        inst_cache_size = '0; inst_cache_wdata = '0;
        data_cache_req = 1'b0; data_cache_addr = '0; data_cache_wr = 1'b0;
        data_cache_size = '0; data_cache_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        inst_done = 1'b0; data_done = 1'b0;
        mem_auto = 1'b1; mem_rand = 1'b0; in_data = 1'b0; phase = 0;
        addr_lat = 0; data_lat = 0;
        stray_addr_ok = 1'b0; stray_data_ok = 1'b0;
        rdata_ovr_en = 1'b0; rdata_ovr = '0;
        last_inst_rd = '0; last_data_rd = '0;
        prev_mem_req = 1'b0;

        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_zero_wait_write();
        test_reset_mid();
        test_spurious_idle();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
